regfile_writeback: RTL and testbench

Write-side front end of the register file. Collects completed results from two producers, the single-cycle ALU and the variable-latency load/store unit (LSU), over valid/ready handshakes. Arbitrates between them fairly and drives the register file's single write port (rd_addr/rd_data/rd_en) from registered outputs. LSU results are buffered in a small FIFO so the LSU is never blocked by ALU traffic for one cycle.

---
 rtl/sp_pkg.sv | 18 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/regfile_writeback.sv | 104 ++++++++++
 tb/tb_regfile_writeback.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared core types and widths used by the register-file write-back front end.
package sp_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned REG_ADDR_WIDTH    = 5;
    localparam int unsigned WB_LSU_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } wb_req_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests; push is ignored when full, pop when empty.
import sp_pkg::*;

module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          push_i,
    input  wb_req_t       push_data_i,
    input  logic          pop_i,
    output wb_req_t       head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    wb_req_t         mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    assign full_o  = (count_r == CW'(DEPTH));
    assign empty_o = (count_r == {CW{1'b0}});
    assign count_o = count_r;
    assign head_o  = mem_r[rd_ptr_r];
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;

    // Storage and pointers; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_i;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port front end: fair ALU/LSU arbitration with a buffered LSU path
// and a registered write port.
import sp_pkg::*;

module regfile_writeback #(
    parameter int unsigned LSU_FIFO_DEPTH = WB_LSU_FIFO_DEPTH,
    localparam int unsigned CW            = $clog2(LSU_FIFO_DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      alu_valid_i,
    output logic                      alu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd_addr_i,
    input  logic [XLEN-1:0]           alu_rd_data_i,
    input  logic                      lsu_valid_i,
    output logic                      lsu_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_rd_addr_i,
    input  logic [XLEN-1:0]           lsu_rd_data_i,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [XLEN-1:0]           rd_data_o,
    output logic                      rd_en_o,
    output logic                      busy_o,
    output logic [CW-1:0]             lsu_count_o
);

    wb_req_t alu_req_s;
    wb_req_t lsu_req_s;
    wb_req_t fifo_head_s;
    wb_req_t win_req_s;
    logic    fifo_full_s;
    logic    fifo_empty_s;
    logic    grant_alu_s;
    logic    grant_lsu_s;
    logic    contested_s;
    wb_src_e last_grant_r;

    assign alu_req_s   = '{addr: alu_rd_addr_i, data: alu_rd_data_i};
    assign lsu_req_s   = '{addr: lsu_rd_addr_i, data: lsu_rd_data_i};
    assign lsu_ready_o = !fifo_full_s;
    assign alu_ready_o = grant_alu_s;
    assign busy_o      = !fifo_empty_s || rd_en_o;

    wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .push_i      (lsu_valid_i && lsu_ready_o),
        .push_data_i (lsu_req_s),
        .pop_i       (grant_lsu_s),
        .head_o      (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .count_o     (lsu_count_o)
    );

    // Grant selection: the buffered LSU head competes with the live ALU request.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
        contested_s = 1'b0;
        if (fifo_empty_s) begin
            grant_alu_s = alu_valid_i;
        end else if (!alu_valid_i) begin
            grant_lsu_s = 1'b1;
        end else begin
            contested_s = 1'b1;
            grant_lsu_s = (last_grant_r == GRANT_ALU);
            grant_alu_s = (last_grant_r == GRANT_LSU);
        end
        if (grant_alu_s) begin
            win_req_s = alu_req_s;
        end else begin
            win_req_s = fifo_head_s;
        end
    end

    // Round-robin history advances only when both sources actually competed.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            last_grant_r <= GRANT_ALU;
        end else if (contested_s) begin
            last_grant_r <= grant_lsu_s ? GRANT_LSU : GRANT_ALU;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Write port register; x0 targets are consumed but never enabled.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rd_addr_o <= {REG_ADDR_WIDTH{1'b0}};
            rd_data_o <= {XLEN{1'b0}};
            rd_en_o   <= 1'b0;
        end else if (grant_alu_s || grant_lsu_s) begin
            rd_addr_o <= win_req_s.addr;
            rd_data_o <= win_req_s.data;
            rd_en_o   <= (win_req_s.addr != {REG_ADDR_WIDTH{1'b0}});
        end else begin
            rd_en_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, reset corner case,
// and randomized traffic against a queue-based reference model.
import sp_pkg::*;

module tb_regfile_writeback;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                      clk_i = 1'b0;
    logic                      arst_ni = 1'b0;
    logic                      alu_valid_i = 1'b0;
    logic                      alu_ready_o;
    logic [REG_ADDR_WIDTH-1:0] alu_rd_addr_i = '0;
    logic [XLEN-1:0]           alu_rd_data_i = '0;
    logic                      lsu_valid_i = 1'b0;
    logic                      lsu_ready_o;
    logic [REG_ADDR_WIDTH-1:0] lsu_rd_addr_i = '0;
    logic [XLEN-1:0]           lsu_rd_data_i = '0;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_o;
    logic [XLEN-1:0]           rd_data_o;
    logic                      rd_en_o;
    logic                      busy_o;
    logic [CW-1:0]             lsu_count_o;

    regfile_writeback #(.LSU_FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_rd_data_i(lsu_rd_data_i),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_en_o(rd_en_o),
        .busy_o(busy_o), .lsu_count_o(lsu_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: queue of buffered LSU results plus who won the last contest.
    wb_req_t                   mq[$];
    bit                        m_last_lsu;
    logic                      m_en;
    logic [REG_ADDR_WIDTH-1:0] m_addr;
    logic [XLEN-1:0]           m_data;
    logic                      m_ar, m_lr;

    task automatic model_reset();
        mq.delete();
        m_last_lsu = 1'b0;
        m_en = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_ready();
        if (mq.size() == 0)   m_ar = alu_valid_i;
        else if (!alu_valid_i) m_ar = 1'b0;
        else                  m_ar = m_last_lsu;
        m_lr = (mq.size() < DEPTH);
    endtask

    task automatic model_edge();
        int      n0 = mq.size();
        bit      g = 1'b0;
        wb_req_t w = '0;
        if (alu_valid_i && m_ar) begin
            w = '{addr: alu_rd_addr_i, data: alu_rd_data_i}; g = 1'b1;
        end else if (n0 != 0) begin
            w = mq.pop_front(); g = 1'b1;
        end
        if (n0 != 0 && alu_valid_i) m_last_lsu = !m_ar;
        if (lsu_valid_i && m_lr) mq.push_back('{addr: lsu_rd_addr_i, data: lsu_rd_data_i});
        if (g) begin
            m_addr = w.addr; m_data = w.data; m_en = (w.addr != '0);
        end else begin
            m_en = 1'b0;
        end
    endtask

    task automatic check_model_ready(input string tag);
        chk({tag, ".alu_ready"}, 64'(alu_ready_o), 64'(m_ar));
        chk({tag, ".lsu_ready"}, 64'(lsu_ready_o), 64'(m_lr));
    endtask

    task automatic check_model_out(input string tag);
        chk({tag, ".rd_en"},   64'(rd_en_o),     64'(m_en));
        chk({tag, ".rd_addr"}, 64'(rd_addr_o),   64'(m_addr));
        chk({tag, ".rd_data"}, 64'(rd_data_o),   64'(m_data));
        chk({tag, ".count"},   64'(lsu_count_o), 64'(mq.size()));
        chk({tag, ".busy"},    64'(busy_o),      64'((mq.size() != 0) || m_en));
    endtask

    // One clock: readies sampled mid-cycle, registered outputs #1 after the edge.
    task automatic cycle(input string tag, input bit do_check);
        #1;
        model_ready();
        if (do_check) check_model_ready(tag);
        @(posedge clk_i);
        model_edge();
        #1;
        if (do_check) check_model_out(tag);
    endtask

    typedef struct {
        logic av; logic [4:0] aa; logic [31:0] ad;
        logic lv; logic [4:0] la; logic [31:0] ld;
        logic e_ar; logic e_lr;
        logic e_en; logic [4:0] e_a; logic [31:0] e_d; logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 2'd0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 32'h1234, 1'b0, 1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF, 2'd1};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd5, 32'h1234,      2'd0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd5, 32'h1234,      2'd0};
        tbl[4]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 2'd0};
        tbl[5]  = '{1'b1, 5'd4, 32'h44,        1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, 5'd4, 32'h44,        2'd0};
        tbl[6]  = '{1'b1, 5'd1, 32'hA1,        1'b1, 5'd2, 32'hB2,   1'b1, 1'b1, 1'b1, 5'd1, 32'hA1,        2'd1};
        tbl[7]  = '{1'b1, 5'd1, 32'hA2,        1'b1, 5'd2, 32'hB3,   1'b0, 1'b1, 1'b1, 5'd2, 32'hB2,        2'd1};
        tbl[8]  = '{1'b1, 5'd1, 32'hA2,        1'b1, 5'd2, 32'hB4,   1'b1, 1'b1, 1'b1, 5'd1, 32'hA2,        2'd2};
        tbl[9]  = '{1'b1, 5'd1, 32'hA3,        1'b1, 5'd2, 32'hB5,   1'b0, 1'b0, 1'b1, 5'd2, 32'hB3,        2'd1};
        tbl[10] = '{1'b1, 5'd1, 32'hA3,        1'b1, 5'd2, 32'hB5,   1'b1, 1'b1, 1'b1, 5'd1, 32'hA3,        2'd2};
        tbl[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd2, 32'hB4,        2'd1};
        tbl[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd2, 32'hB5,        2'd0};
        tbl[13] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd2, 32'hB5,        2'd0};

        model_reset();
        #1;
        chk("reset.rd_en",   64'(rd_en_o),     64'd0);
        chk("reset.rd_addr", 64'(rd_addr_o),   64'd0);
        chk("reset.rd_data", 64'(rd_data_o),   64'd0);
        chk("reset.count",   64'(lsu_count_o), 64'd0);
        chk("reset.busy",    64'(busy_o),      64'd0);
        repeat (2) @(posedge clk_i);
        #2 arst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Directed vectors: single producers, x0, contention and LSU backpressure.
        for (int i = 0; i < 14; i++) begin
            alu_valid_i = tbl[i].av; alu_rd_addr_i = tbl[i].aa; alu_rd_data_i = tbl[i].ad;
            lsu_valid_i = tbl[i].lv; lsu_rd_addr_i = tbl[i].la; lsu_rd_data_i = tbl[i].ld;
            #1;
            model_ready();
            chk($sformatf("vec%0d.alu_ready", i), 64'(alu_ready_o), 64'(tbl[i].e_ar));
            chk($sformatf("vec%0d.lsu_ready", i), 64'(lsu_ready_o), 64'(tbl[i].e_lr));
            @(posedge clk_i);
            model_edge();
            #1;
            chk($sformatf("vec%0d.rd_en", i),   64'(rd_en_o),     64'(tbl[i].e_en));
            chk($sformatf("vec%0d.rd_addr", i), 64'(rd_addr_o),   64'(tbl[i].e_a));
            chk($sformatf("vec%0d.rd_data", i), 64'(rd_data_o),   64'(tbl[i].e_d));
            chk($sformatf("vec%0d.count", i),   64'(lsu_count_o), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.busy", i),    64'(busy_o),
                64'((tbl[i].e_cnt != 2'd0) || tbl[i].e_en));
        end

        // Fill the FIFO with a write in flight, then reset mid-operation.
        alu_valid_i = 1'b1; alu_rd_addr_i = 5'd7; alu_rd_data_i = 32'h77;
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd8; lsu_rd_data_i = 32'h88;
        cycle("fill0", 1'b1);
        alu_rd_data_i = 32'h78; lsu_rd_data_i = 32'h89;
        cycle("fill1", 1'b1);
        lsu_rd_data_i = 32'h8A;
        cycle("fill2", 1'b1);
        chk("prerst.count", 64'(lsu_count_o), 64'd2);
        chk("prerst.rd_en", 64'(rd_en_o),     64'd1);
        arst_ni = 1'b0;
        #1;
        model_reset();
        chk("midrst.rd_en",   64'(rd_en_o),     64'd0);
        chk("midrst.rd_addr", 64'(rd_addr_o),   64'd0);
        chk("midrst.rd_data", 64'(rd_data_o),   64'd0);
        chk("midrst.count",   64'(lsu_count_o), 64'd0);
        chk("midrst.busy",    64'(busy_o),      64'd0);
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        @(posedge clk_i); #2 arst_ni = 1'b1;
        for (int i = 0; i < 3; i++) cycle($sformatf("postrst%0d", i), 1'b1);

        // Random traffic; a producer holds its request until it is accepted.
        for (int i = 0; i < 400; i++) begin
            if (!(alu_valid_i && !m_ar)) begin
                alu_valid_i   = ($urandom_range(0, 9) < 6);
                alu_rd_addr_i = REG_ADDR_WIDTH'($urandom_range(0, 31));
                alu_rd_data_i = $urandom;
            end
            if (!(lsu_valid_i && !m_lr)) begin
                lsu_valid_i   = ($urandom_range(0, 9) < 5);
                lsu_rd_addr_i = REG_ADDR_WIDTH'($urandom_range(0, 31));
                lsu_rd_data_i = $urandom;
            end
            cycle($sformatf("rnd%0d", i), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
